// File: rtl/timer_pkg.sv
// Shared constants and byte-lane helpers for the 68000-bus timer.
// Word indices are addr[7:1]; bit positions index CTRL and STATUS.
package timer_pkg;

    localparam logic [6:0] TMR_CTRL   = 7'd0;
    localparam logic [6:0] TMR_PRESC  = 7'd1;
    localparam logic [6:0] TMR_RELOAD = 7'd2;
    localparam logic [6:0] TMR_COUNT  = 7'd3;
    localparam logic [6:0] TMR_STATUS = 7'd4;

    localparam int EN  = 0;
    localparam int AR  = 1;
    localparam int IE  = 2;
    localparam int EXP = 0;

    function automatic logic [15:0] byte_mask(
        input logic uds,
        input logic lds
    );
        return {{8{uds}}, {8{lds}}};
    endfunction

    function automatic logic [15:0] byte_merge(
        input logic [15:0] old,
        input logic [15:0] wdata,
        input logic        uds,
        input logic        lds
    );
        logic [15:0] m;
        m = byte_mask(uds, lds);
        return (old & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: one-cycle tick every presc+1 enabled clocks.
// clear restarts the phase so a fresh enable gets a full first period.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clear,
    input  logic [15:0] presc,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == presc);
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer.sv
// 16-bit down-counting timer with prescaler, auto-reload and level irq.
// Registered-ack, byte-strobed register access on the 68000 bus.
module timer
    import timer_pkg::*;
#(
    parameter logic [15:0] RESET_RELOAD = 16'hFFFF,
    parameter logic [15:0] RESET_PRESC  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    input  logic [7:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic        rw,
    input  logic        as,
    output logic        ack,
    output logic        irq
);

    logic [6:0]  widx;
    logic        sel, wr, rd, ctrl_wr, exp_clr;
    logic        tick, expire, hw_clr, en_load;
    logic [15:0] mask;
    logic        addr_unused;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic        ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;

    assign addr_unused = addr[0];

    always_comb begin
        widx    = addr[7:1];
        sel     = as && (widx <= TMR_STATUS);
        wr      = sel && !rw;
        rd      = sel && rw;
        mask    = byte_mask(uds, lds);
        ctrl_wr = wr && (widx == TMR_CTRL) && lds;
        exp_clr = wr && (widx == TMR_STATUS) && lds && data_write[EXP];
        expire  = tick && (count_q == 16'd0);
        hw_clr  = expire && !ctrl_q[AR];
        // A rewrite of EN=1 racing the one-shot auto-clear counts as a restart
        en_load = ctrl_wr && data_write[EN] && (!ctrl_q[EN] || hw_clr);
    end

    timer_prescaler u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_q[EN]),
        .clear (en_load),
        .presc (presc_q),
        .tick  (tick)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        reload_d = reload_q;
        count_d  = count_q;
        exp_d    = exp_q;
        ack_d    = sel;
        rdata_d  = '0;

        if (hw_clr) ctrl_d[EN] = 1'b0;
        if (ctrl_wr) ctrl_d = data_write[2:0];

        if (wr && (widx == TMR_PRESC)) begin
            presc_d = byte_merge(presc_q, data_write, uds, lds);
        end
        if (wr && (widx == TMR_RELOAD)) begin
            reload_d = byte_merge(reload_q, data_write, uds, lds);
        end

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (ctrl_q[AR]) begin
                count_d = reload_q;
            end
        end
        if (en_load) count_d = reload_q;

        if (exp_clr) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;

        if (rd) begin
            case (widx)
                TMR_CTRL:   rdata_d = {13'd0, ctrl_q};
                TMR_PRESC:  rdata_d = presc_q;
                TMR_RELOAD: rdata_d = reload_q;
                TMR_COUNT:  rdata_d = count_q;
                TMR_STATUS: rdata_d = {15'd0, exp_q};
                default:    rdata_d = '0;
            endcase
            rdata_d = rdata_d & mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            presc_q  <= RESET_PRESC;
            reload_q <= RESET_RELOAD;
            count_q  <= '0;
            exp_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign data_read = rdata_q;
    assign irq       = exp_q & ctrl_q[IE];

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: a behavioural model queues expected bus
// responses; a negedge monitor pops and compares, plus directed checks.
module tb_timer;

    logic        clk = 1'b0;
    logic        reset, as, rw, uds, lds;
    logic [7:0]  addr;
    logic [15:0] data_write, data_read;
    logic        ack, irq;

    timer dut (
        .clk        (clk),
        .reset      (reset),
        .data_write (data_write),
        .data_read  (data_read),
        .addr       (addr),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .as         (as),
        .ack        (ack),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] sb[$];
    logic [15:0] seq[9] = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1,
                            16'd1, 16'd0, 16'd0, 16'd3};

    bit          m_en, m_ar, m_ie, m_exp;
    logic [15:0] m_presc, m_reload, m_count, m_pcnt;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_presc = 16'h0000; m_reload = 16'hFFFF;
        m_count = 0; m_pcnt = 0;
    endtask

    // One clock of the timer as described by its register-level rules.
    task automatic model_step();
        int w;
        bit mapped, tk, fire;
        bit n_en, n_ar, n_ie, n_exp;
        logic [15:0] mask, v, n_presc, n_reload, n_count, n_pcnt;
        w = int'(addr[7:1]);
        mapped = as && (w <= 4);
        mask = {{8{uds}}, {8{lds}}};
        tk = m_en && (m_pcnt == m_presc);
        fire = tk && (m_count == 0);
        if (mapped) begin
            case (w)
                0: v = {13'd0, m_ie, m_ar, m_en};
                1: v = m_presc;
                2: v = m_reload;
                3: v = m_count;
                default: v = {15'd0, m_exp};
            endcase
            sb.push_back(rw ? (v & mask) : 16'h0);
        end
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_exp = m_exp;
        n_presc = m_presc; n_reload = m_reload;
        n_count = m_count; n_pcnt = m_pcnt;
        if (tk) begin
            n_pcnt = 0;
            if (fire) begin
                n_exp = 1;
                if (m_ar) n_count = m_reload;
                else n_en = 0;
            end else begin
                n_count = m_count - 1;
            end
        end else if (m_en) begin
            n_pcnt = m_pcnt + 1;
        end
        if (mapped && !rw) begin
            case (w)
                0: if (lds) begin
                    if (data_write[0] && (!m_en || (fire && !m_ar))) begin
                        n_count = m_reload;
                        n_pcnt = 0;
                    end
                    n_en = data_write[0];
                    n_ar = data_write[1];
                    n_ie = data_write[2];
                end
                1: n_presc = (m_presc & ~mask) | (data_write & mask);
                2: n_reload = (m_reload & ~mask) | (data_write & mask);
                4: if (lds && data_write[0] && !fire) n_exp = 0;
                default: ;
            endcase
        end
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_exp = n_exp;
        m_presc = n_presc; m_reload = n_reload;
        m_count = n_count; m_pcnt = n_pcnt;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin : mon
        logic [15:0] e;
        check("ack", {15'd0, ack}, (sb.size() != 0) ? 16'd1 : 16'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data_read", data_read, e);
        end else begin
            check("idle_data", data_read, 16'h0);
        end
        check("irq", {15'd0, irq}, {15'd0, m_exp & m_ie});
    end

    task automatic bus_now(input int w, input bit r, input logic [15:0] d,
                           input bit u, input bit l, input int hold);
        addr = {w[6:0], 1'b0};
        as = 1; rw = r; data_write = d; uds = u; lds = l;
        repeat (hold) @(negedge clk);
        as = 0; rw = 1; uds = 0; lds = 0; data_write = 0;
    endtask

    task automatic bus(input int w, input bit r, input logic [15:0] d,
                       input bit u, input bit l, input int hold);
        @(negedge clk);
        bus_now(w, r, d, u, l, hold);
    endtask

    task automatic wr(input int w, input logic [15:0] d);
        bus(w, 1'b0, d, 1'b1, 1'b1, 1);
    endtask

    task automatic rd_chk(input int w, input logic [15:0] req, input string name);
        bus(w, 1'b1, 16'h0, 1'b1, 1'b1, 1);
        check({name, "_ack"}, {15'd0, ack}, 16'd1);
        check(name, data_read, req);
    endtask

    task automatic rd_reset_vals(input string tag);
        rd_chk(0, 16'h0000, {tag, "_ctrl"});
        rd_chk(1, 16'h0000, {tag, "_presc"});
        rd_chk(2, 16'hFFFF, {tag, "_reload"});
        rd_chk(3, 16'h0000, {tag, "_count"});
        rd_chk(4, 16'h0000, {tag, "_status"});
    endtask

    initial begin
        int e0;
        reset = 1; as = 0; rw = 1; uds = 0; lds = 0;
        addr = 0; data_write = 0;
        repeat (3) @(negedge clk);
        reset = 0;

        rd_reset_vals("rst");
        @(negedge clk);
        check("ack_one_clk", {15'd0, ack}, 16'd0);

        // periodic: PRESC=1, RELOAD=3, all CTRL bits set
        wr(1, 16'd1);
        wr(2, 16'd3);
        wr(0, 16'd7);
        e0 = cyc;
        bus_now(3, 1'b1, 16'h0, 1'b1, 1'b1, 0);
        as = 1; rw = 1; uds = 1; lds = 1; addr = {7'd3, 1'b0};
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("per_count", data_read, seq[k-1]);
            check("per_irq", {15'd0, irq}, (k >= 8) ? 16'd1 : 16'd0);
        end
        as = 0; uds = 0; lds = 0;
        wr(4, 16'd1);
        check("clr_irq", {15'd0, irq}, 16'd0);
        while (cyc < e0 + 15) @(negedge clk);
        bus_now(4, 1'b0, 16'd1, 1'b1, 1'b1, 1);
        check("set_wins_irq", {15'd0, irq}, 16'd1);
        rd_chk(4, 16'd1, "set_wins_exp");
        wr(4, 16'd1);
        check("late_clr_irq", {15'd0, irq}, 16'd0);
        wr(0, 16'd0);

        // one-shot: RELOAD=2, PRESC=0, EN+IE
        wr(2, 16'd2);
        wr(1, 16'd0);
        wr(0, 16'd5);
        e0 = cyc;
        repeat (2) @(negedge clk);
        check("os_irq_early", {15'd0, irq}, 16'd0);
        @(negedge clk);
        check("os_irq_set", {15'd0, irq}, 16'd1);
        rd_chk(0, 16'd4, "os_ctrl");
        rd_chk(3, 16'd0, "os_count");
        rd_chk(4, 16'd1, "os_exp");
        wr(4, 16'd1);
        wr(0, 16'd0);

        // byte strobes and unmapped word
        wr(2, 16'h0000);
        bus(2, 1'b0, 16'hABCD, 1'b1, 1'b0, 1);
        rd_chk(2, 16'hAB00, "uds_reload");
        bus(2, 1'b1, 16'h0, 1'b0, 1'b1, 1);
        check("lds_read", data_read, 16'h0000);
        bus(5, 1'b0, 16'h1234, 1'b1, 1'b1, 1);
        check("w5_wr_noack", {15'd0, ack}, 16'd0);
        bus(5, 1'b1, 16'h0, 1'b1, 1'b1, 1);
        check("w5_rd_noack", {15'd0, ack}, 16'd0);
        rd_chk(2, 16'hAB00, "w5_reload");

        // reset mid-count with irq high, during a bus cycle
        wr(1, 16'd0);
        wr(2, 16'd1);
        wr(0, 16'd7);
        repeat (4) @(negedge clk);
        check("pre_rst_irq", {15'd0, irq}, 16'd1);
        reset = 1;
        bus_now(3, 1'b1, 16'h0, 1'b1, 1'b1, 1);
        check("rst_irq", {15'd0, irq}, 16'd0);
        check("rst_noack", {15'd0, ack}, 16'd0);
        reset = 0;
        rd_reset_vals("mid_rst");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int w, sel, hold;
            bit r, u, l;
            logic [15:0] d;
            w = $urandom_range(0, 5);
            r = 1'($urandom_range(0, 1));
            case (w)
                0: d = 16'($urandom_range(0, 7));
                1: d = 16'($urandom_range(0, 3));
                2: d = 16'($urandom_range(0, 7));
                4: d = 16'($urandom_range(0, 1));
                default: d = 16'($urandom);
            endcase
            if (w == 1 && !r && m_en) r = 1;
            sel = $urandom_range(0, 3);
            u = (sel != 1);
            l = (sel != 0);
            hold = $urandom_range(1, 3);
            bus(w, r, d, u, l, hold);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                reset = 1;
                @(negedge clk);
                reset = 0;
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
